tinker_mem_arbiter: RTL and testbench

Shares the single byte-addressed Tinker memory between the instruction-fetch requester and the data requester (load, store, call-push, return-pop). It sits between the core sequencer and the memory array and replaces the ad-hoc fetchFlag/memFlag multiplexing with valid/ready request ports and one outstanding access at a time. It also adds fixed-latency memory sequencing, 2-way round-robin arbitration, range/alignment fault checking and fetch flush on PC redirect.

---
 rtl/tinker_mem_arbiter_pkg.sv | 28 ++
 rtl/tinker_mem_arbiter_if.sv | 77 +++++++
 rtl/tinker_mem_arbiter_arb.sv | 35 +++
 rtl/tinker_mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_tinker_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_mem_arbiter_pkg.sv
// Shared types and constants for the Tinker memory arbiter.
// Imported by the arbiter, its picker and the bench.
package tinker_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } port_e;

  localparam int unsigned MEM_BYTES_DEF = 524288;

  localparam logic SZ_W4 = 1'b0;
  localparam logic SZ_W8 = 1'b1;

  function automatic logic [64:0] size_bytes(
    input logic sz
  );
    return sz ? 65'd8 : 65'd4;
  endfunction

endpackage

// File: rtl/tinker_mem_arbiter_if.sv
// Request/response and memory bus bundle of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface tinker_mem_arbiter_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_addr;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_data;
  logic        d_rsp_err;

  logic        mem_en;
  logic        mem_we;
  logic        mem_size;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  if_req_valid,
    input  if_addr,
    input  if_flush,
    input  d_req_valid,
    input  d_req_we,
    input  d_addr,
    input  d_wdata,
    input  mem_rdata,
    output if_req_ready,
    output if_rsp_valid,
    output if_rsp_data,
    output if_rsp_err,
    output d_req_ready,
    output d_rsp_valid,
    output d_rsp_data,
    output d_rsp_err,
    output mem_en,
    output mem_we,
    output mem_size,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output if_req_valid,
    output if_addr,
    output if_flush,
    output d_req_valid,
    output d_req_we,
    output d_addr,
    output d_wdata,
    output mem_rdata,
    input  if_req_ready,
    input  if_rsp_valid,
    input  if_rsp_data,
    input  if_rsp_err,
    input  d_req_ready,
    input  d_rsp_valid,
    input  d_rsp_data,
    input  d_rsp_err,
    input  mem_en,
    input  mem_we,
    input  mem_size,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/tinker_mem_arbiter_arb.sv
// Two-way round-robin picker; last_grant moves only on a
// completed handshake so an unaccepted offer never rotates.
module tinker_rr_arb2
  import tinker_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_if,
  input  logic req_d,
  input  logic update,
  output logic gnt_if,
  output logic gnt_d
);

  port_e last_q;
  port_e last_d;

  always_comb begin
    gnt_if = req_if & (~req_d | (last_q == PORT_D));
    gnt_d  = req_d & ~gnt_if;
    last_d = last_q;
    if (update) begin
      last_d = gnt_if ? PORT_IF : PORT_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= PORT_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Single-outstanding arbiter between fetch and data requesters
// in front of the fixed-latency Tinker memory.
module tinker_mem_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  tinker_mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_e        state_q, state_d;
  port_e         port_q, port_d;
  logic          we_q, we_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0]   if_rsp_data_q, if_rsp_data_d;
  logic          if_rsp_err_q, if_rsp_err_d;
  logic          d_rsp_valid_q, d_rsp_valid_d;
  logic [63:0]   d_rsp_data_q, d_rsp_data_d;
  logic          d_rsp_err_q, d_rsp_err_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_size_q, mem_size_d;
  logic [63:0]   mem_addr_q, mem_addr_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;

  logic          req_if, req_d;
  logic          gnt_if, gnt_d;
  logic          hs;
  logic [63:0]   sel_addr;
  logic [63:0]   sel_wdata;
  logic          sel_we;
  logic          sel_size;
  logic [64:0]   end_addr;
  logic          fault;

  assign req_if = bus.if_req_valid & (state_q == IDLE) & ~reset;
  assign req_d  = bus.d_req_valid & (state_q == IDLE) & ~reset;
  assign hs     = gnt_if | gnt_d;

  tinker_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_if (req_if),
    .req_d  (req_d),
    .update (hs),
    .gnt_if (gnt_if),
    .gnt_d  (gnt_d)
  );

  assign sel_addr  = gnt_if ? bus.if_addr : bus.d_addr;
  assign sel_wdata = gnt_if ? 64'd0 : bus.d_wdata;
  assign sel_we    = gnt_d & bus.d_req_we;
  assign sel_size  = gnt_if ? SZ_W4 : SZ_W8;

  // 65-bit sum so addresses near 2^64 fault instead of wrapping
  assign end_addr = {1'b0, sel_addr} + size_bytes(sel_size);
  assign fault    = (end_addr > 65'(MEM_BYTES))
                  | (gnt_if & (sel_addr[1:0] != 2'b00));

  always_comb begin
    state_d        = state_q;
    port_d         = port_q;
    we_d           = we_q;
    drop_d         = drop_q;
    cnt_d          = cnt_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    if_rsp_err_d   = if_rsp_err_q;
    d_rsp_valid_d  = 1'b0;
    d_rsp_data_d   = d_rsp_data_q;
    d_rsp_err_d    = d_rsp_err_q;
    mem_en_d       = 1'b0;
    mem_we_d       = mem_we_q;
    mem_size_d     = mem_size_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;

    if ((state_q != IDLE) && (port_q == PORT_IF)
        && bus.if_flush) begin
      drop_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          port_d = gnt_if ? PORT_IF : PORT_D;
          we_d   = sel_we;
          drop_d = 1'b0;
          if (fault) begin
            state_d = RESP;
            if (gnt_if) begin
              if_rsp_valid_d = 1'b1;
              if_rsp_data_d  = 32'd0;
              if_rsp_err_d   = 1'b1;
            end else begin
              d_rsp_valid_d = 1'b1;
              d_rsp_data_d  = 64'd0;
              d_rsp_err_d   = 1'b1;
            end
          end else begin
            state_d     = ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_size_d  = sel_size;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CW'(1);
      end
      WAIT: begin
        if (cnt_q == CW'(MEM_LAT)) begin
          state_d = RESP;
          if (port_q == PORT_IF) begin
            if_rsp_valid_d = ~drop_d;
            if_rsp_data_d  = bus.mem_rdata[31:0];
            if_rsp_err_d   = 1'b0;
          end else begin
            d_rsp_valid_d = 1'b1;
            d_rsp_data_d  = we_q ? 64'd0 : bus.mem_rdata;
            d_rsp_err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      port_q         <= PORT_IF;
      we_q           <= 1'b0;
      drop_q         <= 1'b0;
      cnt_q          <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= 32'd0;
      if_rsp_err_q   <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_data_q   <= 64'd0;
      d_rsp_err_q    <= 1'b0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_size_q     <= 1'b0;
      mem_addr_q     <= 64'd0;
      mem_wdata_q    <= 64'd0;
    end else begin
      state_q        <= state_d;
      port_q         <= port_d;
      we_q           <= we_d;
      drop_q         <= drop_d;
      cnt_q          <= cnt_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_data_q   <= d_rsp_data_d;
      d_rsp_err_q    <= d_rsp_err_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_size_q     <= mem_size_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign bus.if_req_ready = gnt_if;
  assign bus.d_req_ready  = gnt_d;
  // a flush landing on the response cycle still hides the pulse
  assign bus.if_rsp_valid = if_rsp_valid_q & ~bus.if_flush;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.if_rsp_err   = if_rsp_err_q;
  assign bus.d_rsp_valid  = d_rsp_valid_q;
  assign bus.d_rsp_data   = d_rsp_data_q;
  assign bus.d_rsp_err    = d_rsp_err_q;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_size     = mem_size_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Directed bench for tinker_mem_arbiter with a byte memory
// model returning read data MEM_LAT cycles after mem_en.
module tb_tinker_mem_arbiter;
  import tinker_mem_pkg::*;

  localparam int LAT = 2;

  logic clk;
  logic reset;
  tinker_mem_arbiter_if bus();

  tinker_mem_arbiter #(
    .MEM_BYTES (524288),
    .MEM_LAT   (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [bit [63:0]];
  logic [63:0] pipe [LAT];

  function automatic logic [63:0] rd(
    input logic [63:0] a,
    input logic        sz8
  );
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if ((i < 4 || sz8) && mem.exists(a + 64'(i)))
        v[8*i +: 8] = mem[a + 64'(i)];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (i < 4 || bus.mem_size)
          mem[bus.mem_addr + 64'(i)] = bus.mem_wdata[8*i +: 8];
      end
    end
    if (bus.mem_en && !bus.mem_we)
      pipe[0] <= rd(bus.mem_addr, bus.mem_size);
    else
      pipe[0] <= 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.mem_rdata = pipe[LAT-1];

  int n_chk;
  int n_fail;

  task automatic check_eq(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  int          r_en, r_rsp, r_rdy, r_wrong;
  logic [63:0] r_data, r_addr;
  logic        r_err, r_size, r_we;

  // one request from an idle arbiter, observed for 8 cycles;
  // ready is probed each cycle without letting it handshake
  task run_req(
    input bit          is_d,
    input bit          we,
    input logic [63:0] addr,
    input logic [63:0] wdata,
    input int          flush_k
  );
    bus.if_req_valid = !is_d;
    bus.if_addr      = addr;
    bus.d_req_valid  = is_d;
    bus.d_req_we     = we;
    bus.d_addr       = addr;
    bus.d_wdata      = wdata;
    #1;
    check_eq("req_ready",
             is_d ? bus.d_req_ready : bus.if_req_ready, 1);
    r_en = -1; r_rsp = -1; r_rdy = -1; r_wrong = 0;
    r_data = 0; r_err = 0; r_addr = 0; r_size = 0; r_we = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.if_req_valid = 1'b0;
      bus.d_req_valid  = 1'b0;
      bus.if_flush     = (k == flush_k);
      #1;
      if (bus.mem_en && r_en < 0) begin
        r_en = k; r_addr = bus.mem_addr;
        r_size = bus.mem_size; r_we = bus.mem_we;
      end
      if (is_d ? bus.d_rsp_valid : bus.if_rsp_valid) begin
        r_rsp  = k;
        r_data = is_d ? bus.d_rsp_data
                      : {32'd0, bus.if_rsp_data};
        r_err  = is_d ? bus.d_rsp_err : bus.if_rsp_err;
      end
      if (is_d ? bus.if_rsp_valid : bus.d_rsp_valid)
        r_wrong++;
      if (is_d) bus.d_req_valid = 1'b1;
      else bus.if_req_valid = 1'b1;
      #1;
      if ((is_d ? bus.d_req_ready : bus.if_req_ready)
          && r_rdy < 0)
        r_rdy = k;
      bus.if_req_valid = 1'b0;
      bus.d_req_valid  = 1'b0;
    end
    bus.if_flush = 1'b0;
  endtask

  int          g [8];
  int          rp [8];
  logic [63:0] rd_if, rd_d;
  int          ng, nr, both, cnt;

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    bus.if_req_valid = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.d_req_valid = 0; bus.d_req_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    for (int i = 0; i < LAT; i++) pipe[i] = 0;
    mem[64'h2000] = 8'h00; mem[64'h2001] = 8'h00;
    mem[64'h2002] = 8'h00; mem[64'h2003] = 8'h8C;

    // reset state
    @(negedge clk);
    bus.if_req_valid = 1; bus.d_req_valid = 1;
    #1;
    check_eq("rst_if_ready", bus.if_req_ready, 0);
    check_eq("rst_d_ready", bus.d_req_ready, 0);
    check_eq("rst_mem_en", bus.mem_en, 0);
    check_eq("rst_rsp", {bus.if_rsp_valid, bus.d_rsp_valid}, 0);
    bus.if_req_valid = 0; bus.d_req_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // basic fetch
    run_req(0, 0, 64'h2000, 0, 0);
    check_eq("f_en_cyc", r_en, 1);
    check_eq("f_size", r_size, SZ_W4);
    check_eq("f_addr", r_addr, 64'h2000);
    check_eq("f_rsp_cyc", r_rsp, 4);
    check_eq("f_data", r_data, 64'h8C00_0000);
    check_eq("f_err", r_err, 0);
    check_eq("f_wrong", r_wrong, 0);
    check_eq("f_rdy_cyc", r_rdy, 5);

    // store then load at the top of memory
    run_req(1, 1, 64'h7FFF8, 64'h1122334455667788, 0);
    check_eq("st_en_cyc", r_en, 1);
    check_eq("st_we", r_we, 1);
    check_eq("st_size", r_size, SZ_W8);
    check_eq("st_rsp_cyc", r_rsp, 4);
    check_eq("st_data", r_data, 0);
    check_eq("st_err", r_err, 0);
    check_eq("st_wrong", r_wrong, 0);
    run_req(1, 0, 64'h7FFF8, 64'h0, 0);
    check_eq("ld_we", r_we, 0);
    check_eq("ld_rsp_cyc", r_rsp, 4);
    check_eq("ld_data", r_data, 64'h1122334455667788);
    check_eq("ld_err", r_err, 0);

    // last legal fetch word
    run_req(0, 0, 64'h7FFFC, 0, 0);
    check_eq("fe_rsp_cyc", r_rsp, 4);
    check_eq("fe_data", r_data, 64'h1122_3344);
    check_eq("fe_err", r_err, 0);

    // faults
    run_req(1, 0, 64'h7FFFC, 0, 0);
    check_eq("dflt_rsp_cyc", r_rsp, 1);
    check_eq("dflt_err", r_err, 1);
    check_eq("dflt_data", r_data, 0);
    check_eq("dflt_en", r_en, -1);
    check_eq("dflt_rdy_cyc", r_rdy, 2);
    run_req(0, 0, 64'h2002, 0, 0);
    check_eq("fmis_rsp_cyc", r_rsp, 1);
    check_eq("fmis_err", r_err, 1);
    check_eq("fmis_en", r_en, -1);
    run_req(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h5, 0);
    check_eq("dwrap_err", r_err, 1);
    check_eq("dwrap_en", r_en, -1);

    // flush in WAIT and in RESP, and on a data access
    run_req(0, 0, 64'h2000, 0, 2);
    check_eq("fl2_en_cyc", r_en, 1);
    check_eq("fl2_rsp", r_rsp, -1);
    check_eq("fl2_rdy_cyc", r_rdy, 5);
    run_req(0, 0, 64'h2000, 0, 4);
    check_eq("fl4_rsp", r_rsp, -1);
    run_req(1, 0, 64'h7FFF8, 0, 2);
    check_eq("fld_rsp_cyc", r_rsp, 4);
    check_eq("fld_data", r_data, 64'h1122334455667788);

    // both requesters held valid from reset
    reset = 1'b1;
    bus.if_addr = 64'h2000;
    bus.d_addr = 64'h7FFF8; bus.d_req_we = 0;
    bus.if_req_valid = 1; bus.d_req_valid = 1;
    @(negedge clk);
    reset = 1'b0;
    ng = 0; nr = 0; both = 0; rd_if = 0; rd_d = 0;
    for (int i = 0; i < 8; i++) begin g[i] = -1; rp[i] = -1; end
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (bus.if_req_ready && bus.d_req_ready) both++;
      if (bus.if_req_ready && ng < 8) begin g[ng] = 0; ng++; end
      if (bus.d_req_ready && ng < 8) begin g[ng] = 1; ng++; end
      if (bus.if_rsp_valid && nr < 8) begin
        rp[nr] = 0; nr++; rd_if = {32'd0, bus.if_rsp_data};
      end
      if (bus.d_rsp_valid && nr < 8) begin
        rp[nr] = 1; nr++; rd_d = bus.d_rsp_data;
      end
    end
    bus.if_req_valid = 0; bus.d_req_valid = 0;
    check_eq("rr_both", both, 0);
    check_eq("rr_ngrant", ng, 4);
    check_eq("rr_nrsp", nr, 4);
    check_eq("rr_grants", {g[0][7:0], g[1][7:0],
                           g[2][7:0], g[3][7:0]}, 32'h00010001);
    check_eq("rr_rsps", {rp[0][7:0], rp[1][7:0],
                         rp[2][7:0], rp[3][7:0]}, 32'h00010001);
    check_eq("rr_if_data", rd_if, 64'h8C00_0000);
    check_eq("rr_d_data", rd_d, 64'h1122334455667788);

    // reset while a fetch sits in WAIT
    @(negedge clk);
    repeat (6) @(negedge clk);
    bus.if_req_valid = 1; bus.if_addr = 64'h2000;
    #1;
    check_eq("rw_ready", bus.if_req_ready, 1);
    @(negedge clk);
    bus.if_req_valid = 0;
    #1;
    check_eq("rw_en", bus.mem_en, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rw_mem_addr", bus.mem_addr, 0);
    check_eq("rw_mem_ctl", {bus.mem_en, bus.mem_we,
                            bus.mem_size}, 0);
    check_eq("rw_mem_wdata", bus.mem_wdata, 0);
    check_eq("rw_d_data", bus.d_rsp_data, 0);
    check_eq("rw_rsp", {bus.if_rsp_valid, bus.if_rsp_err,
                        bus.d_rsp_valid, bus.d_rsp_err}, 0);
    check_eq("rw_if_data", bus.if_rsp_data, 0);
    bus.if_req_valid = 1;
    #1;
    check_eq("rw_rst_ready", bus.if_req_ready, 0);
    bus.if_req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (bus.if_rsp_valid || bus.d_rsp_valid) cnt++;
    end
    check_eq("rw_no_rsp", cnt, 0);
    bus.if_req_valid = 1; bus.d_req_valid = 1;
    #1;
    check_eq("rw_tie_if", bus.if_req_ready, 1);
    check_eq("rw_tie_d", bus.d_req_ready, 0);
    bus.if_req_valid = 0; bus.d_req_valid = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
